// File: rtl/dma_pkg.sv
// dma_pkg: shared state encoding, width helper and reset constants for the DMA priority resolver
package dma_pkg;
  typedef enum logic [1:0] {IDLE, REQ, SERVICE, RELEASE} pr_state_t;
  localparam pr_state_t RST_STATE = IDLE;
  localparam logic RST_HRQ = 1'b0;
  localparam logic RST_VALID = 1'b0;
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/dma_rr_pick.sv
// dma_rr_pick: first eligible channel scanning upward from prio_ptr, wrapping modulo NUM_CH
module dma_rr_pick
  import dma_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W = ch_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] eligible,
  input  logic [CH_W-1:0]   prio_ptr,
  output logic [NUM_CH-1:0] onehot,
  output logic [CH_W-1:0]   bin
);
  logic [CH_W-1:0] idx;
  always_comb begin
    onehot = '0;
    bin = '0;
    idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = CH_W'((int'(prio_ptr) + i) % NUM_CH);
      if (eligible[idx]) begin
        onehot = '0;
        onehot[idx] = 1'b1;
        bin = idx;
      end
    end
  end
endmodule

// File: rtl/dma_priority_resolver_n.sv
// dma_priority_resolver_n: N-channel DMA request qualification, priority arbitration and HRQ/HLDA grant handshake
module dma_priority_resolver_n
  import dma_pkg::*;
#(
  parameter int NUM_CH = 4,
  localparam int CH_W = ch_w(NUM_CH)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NUM_CH-1:0] DREQ,
  input  logic              dreqActiveLow,
  input  logic              dackActiveHigh,
  input  logic              rotatePriority,
  input  logic              ctrlDisable,
  input  logic [NUM_CH-1:0] mask,
  input  logic [NUM_CH-1:0] softReqSet,
  input  logic              HLDA,
  input  logic              serviceDone,
  output logic              hrq,
  output logic [NUM_CH-1:0] VALID_DREQ,
  output logic              validDACK,
  output logic [NUM_CH-1:0] DACK,
  output logic [CH_W-1:0]   chanIdx,
  output logic [CH_W-1:0]   prioPtr
);
  pr_state_t state, state_n;
  logic [NUM_CH-1:0] soft_req, eligible, pick_oh;
  logic [CH_W-1:0] pick_bin;
  logic grant, done;
  assign eligible = ctrlDisable ? '0 : ((DREQ ^ {NUM_CH{dreqActiveLow}}) | soft_req) & ~mask;
  assign grant = state == REQ && HLDA && |eligible;
  assign done = state == SERVICE && serviceDone;
  assign DACK = VALID_DREQ ^ {NUM_CH{~dackActiveHigh}};
  dma_rr_pick #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_pick (
    .eligible(eligible),
    .prio_ptr(prioPtr),
    .onehot(pick_oh),
    .bin(pick_bin)
  );
  always_ff @(posedge CLK) state <= RESET ? RST_STATE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = |eligible ? REQ : IDLE;
      REQ:     state_n = ~|eligible ? IDLE : HLDA ? SERVICE : REQ;
      SERVICE: state_n = serviceDone ? RELEASE : SERVICE;
      RELEASE: state_n = HLDA ? RELEASE : IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      hrq <= RST_HRQ;
      VALID_DREQ <= '0;
      validDACK <= RST_VALID;
      chanIdx <= '0;
      prioPtr <= '0;
      soft_req <= '0;
    end else begin
      hrq <= state_n == REQ || state_n == SERVICE;
      VALID_DREQ <= grant ? pick_oh : done ? '0 : VALID_DREQ;
      validDACK <= grant ? 1'b1 : done ? 1'b0 : validDACK;
      chanIdx <= grant ? pick_bin : chanIdx;
      prioPtr <= !rotatePriority ? '0 : !done ? prioPtr : chanIdx == CH_W'(NUM_CH - 1) ? '0 : chanIdx + CH_W'(1);
      soft_req <= (soft_req & ~(done ? VALID_DREQ : '0)) | softReqSet;
    end
  end
endmodule
